// File: rtl/vita49_pkg.sv
// -----------------------------------------------------------------------------
// vita49_pkg
// Shared definitions for the VITA49 unpacker:
//   - header word bit positions
//   - the IF-data-with-stream-ID packet type code
//   - the number of fixed header words (w0..w4)
//   - the parser FSM state enum
//   - small helpers for the payload length arithmetic
// -----------------------------------------------------------------------------
package vita49_pkg;

  // Header word (w0) field positions
  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_C_BIT    = 27;
  localparam int HDR_T_BIT    = 26;
  localparam int HDR_CNT_MSB  = 19;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_SIZE_MSB = 15;
  localparam int HDR_SIZE_LSB = 0;

  localparam logic [3:0] VITA49_TYPE_IFDATA_SID = 4'b0001;

  // header, stream ID, integer seconds, fractional seconds (2 words)
  localparam int VITA49_HDR_WORDS = 5;

  typedef enum logic [2:0] {
    IDLE,
    SID,
    TS_SEC,
    TSF_HI,
    TSF_LO,
    PAYLOAD,
    TRAILER,
    DROP
  } state_t;

  // Number of payload words carried by a packet of 'size' words.
  function automatic logic [15:0] payload_words(input logic [15:0] size,
                                                input logic        trailer);
    return size - 16'(VITA49_HDR_WORDS) - {15'd0, trailer};
  endfunction

  // Smallest legal size: all header words, one payload word, optional trailer.
  function automatic logic [15:0] min_size(input logic trailer);
    return 16'(VITA49_HDR_WORDS + 1) + {15'd0, trailer};
  endfunction

endpackage

// File: rtl/vita49_skid.sv
// -----------------------------------------------------------------------------
// vita49_skid
// AXI-stream register slice for the payload output. The output register gives
// one cycle of latency; a second (skid) register absorbs the beat accepted in
// the cycle the sink stalls, so in_ready is a pure register output and never
// depends combinationally on out_ready, while still sustaining 1 word/cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_data/in_last/in_valid      upstream beat
//   in_ready                      registered; low during and right after reset
//   out_data/out_last/out_valid   downstream beat
//   out_ready                     downstream acceptance
// -----------------------------------------------------------------------------
module vita49_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_data_reg, out_data_next;
  logic        out_last_reg, out_last_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_data_reg, skid_data_next;
  logic        skid_last_reg, skid_last_next;
  logic        in_ready_reg;
  logic        in_fire;

  assign in_fire = in_valid && in_ready_reg;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_last_next   = out_last_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_last_next  = skid_last_reg;
    if (!out_valid_reg || out_ready) begin
      // Output register is free this cycle: refill from skid first to keep order.
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        out_last_next   = skid_last_reg;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = in_fire;
        if (in_fire) begin
          out_data_next = in_data;
          out_last_next = in_last;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the accepted beat in the skid register.
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
      skid_last_next  = in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_last_reg   <= out_last_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_last_reg  <= skid_last_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: rtl/vita49_unpack.sv
// -----------------------------------------------------------------------------
// vita49_unpack
// Parses VITA49 IF-data packets (with stream ID, integer + fractional
// timestamps, optional trailer) from an AXI stream, publishes the header
// fields with a one-cycle strobe and forwards only the payload words.
// Malformed packets are counted in saturating error counters.
//
// Parameters:
//   CNT_W      width of each error counter
//   CHECK_SEQ  1 = check the 4-bit packet count increments mod 16
//
// Ports:
//   AXIS_ACLK, AXIS_ARESET        clock, asynchronous active-high reset
//   S_AXIS_*                      packet input stream
//   M_AXIS_*                      payload-only output stream (1-cycle latency)
//   enable                        low: no new packet accepted
//   pkt_stream_id/ts_sec/ts_fsec  header fields of the last good packet
//   pkt_info_valid                strobe when those fields update
//   err_len_cnt/seq_cnt/type_cnt  saturating error counters
//   busy                          FSM not in IDLE
//
// Optional feature: define VITA49_UNPACK_SID_FILTER_EN to add sid_filter_en /
// sid_filter inputs; packets whose stream ID differs are silently dropped.
// -----------------------------------------------------------------------------
module vita49_unpack
  import vita49_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int CHECK_SEQ = 1
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESET,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [31:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  input  logic             enable,
`ifdef VITA49_UNPACK_SID_FILTER_EN
  input  logic             sid_filter_en,
  input  logic [31:0]      sid_filter,
`endif
  output logic [31:0]      pkt_stream_id,
  output logic [31:0]      pkt_ts_sec,
  output logic [63:0]      pkt_ts_fsec,
  output logic             pkt_info_valid,
  output logic [CNT_W-1:0] err_len_cnt,
  output logic [CNT_W-1:0] err_seq_cnt,
  output logic [CNT_W-1:0] err_type_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_reg, state_next;

  logic        run_reg;          // holds off S_AXIS_TREADY for the cycle after reset
  logic        t_reg;
  logic [15:0] rem_reg;          // payload words still to forward
  logic [3:0]  cnt_reg;
  logic [3:0]  prev_cnt_reg;
  logic        seq_seen_reg;
  logic [31:0] sid_shadow_reg;
  logic [31:0] sec_shadow_reg;
  logic [31:0] fsec_hi_reg;

  logic [31:0] pkt_stream_id_reg;
  logic [31:0] pkt_ts_sec_reg;
  logic [63:0] pkt_ts_fsec_reg;
  logic        pkt_info_valid_reg;
  logic [CNT_W-1:0] err_len_reg;
  logic [CNT_W-1:0] err_seq_reg;
  logic [CNT_W-1:0] err_type_reg;

  logic        beat;
  logic        hdr_bad;
  logic        last_word;
  logic        end_here;         // TLAST belongs on this payload word
  logic        seq_bad;
  logic        sid_reject;
  logic        skid_ready;
  logic        skid_in_valid;
  logic        skid_in_last;
  logic        len_err;
  logic        type_err;
  logic        seq_commit;
  logic        info_load;

  assign beat      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign hdr_bad   = (S_AXIS_TDATA[HDR_TYPE_MSB:HDR_TYPE_LSB] != VITA49_TYPE_IFDATA_SID)
                  || S_AXIS_TDATA[HDR_C_BIT]
                  || (S_AXIS_TDATA[HDR_SIZE_MSB:HDR_SIZE_LSB] < min_size(S_AXIS_TDATA[HDR_T_BIT]));
  assign last_word = (rem_reg == 16'd1);
  assign end_here  = last_word && !t_reg;
  assign seq_bad   = (CHECK_SEQ != 0) && seq_seen_reg && (cnt_reg != 4'(prev_cnt_reg + 4'd1));

`ifdef VITA49_UNPACK_SID_FILTER_EN
  assign sid_reject = sid_filter_en && (S_AXIS_TDATA != sid_filter);
`else
  assign sid_reject = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (beat && !S_AXIS_TLAST) state_next = hdr_bad ? DROP : SID;
      SID:     if (beat) state_next = S_AXIS_TLAST ? IDLE : (sid_reject ? DROP : TS_SEC);
      TS_SEC:  if (beat) state_next = S_AXIS_TLAST ? IDLE : TSF_HI;
      TSF_HI:  if (beat) state_next = S_AXIS_TLAST ? IDLE : TSF_LO;
      TSF_LO:  if (beat) state_next = S_AXIS_TLAST ? IDLE : PAYLOAD;
      PAYLOAD: begin
        if (beat) begin
          if (S_AXIS_TLAST)   state_next = IDLE;
          else if (last_word) state_next = t_reg ? TRAILER : DROP;
        end
      end
      TRAILER: if (beat) state_next = S_AXIS_TLAST ? IDLE : DROP;
      DROP:    if (beat && S_AXIS_TLAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    S_AXIS_TREADY = run_reg;
    skid_in_valid = 1'b0;
    skid_in_last  = 1'b0;
    len_err       = 1'b0;
    type_err      = 1'b0;
    seq_commit    = 1'b0;
    info_load     = 1'b0;
    case (state_reg)
      IDLE: begin
        S_AXIS_TREADY = run_reg && enable;
        type_err      = beat && hdr_bad;
        len_err       = beat && !hdr_bad && S_AXIS_TLAST;
      end
      SID: begin
        // Sequence is judged here so a filtered stream leaves no trace.
        seq_commit = beat && !sid_reject;
        len_err    = beat && !sid_reject && S_AXIS_TLAST;
      end
      TS_SEC, TSF_HI: begin
        len_err = beat && S_AXIS_TLAST;
      end
      TSF_LO: begin
        len_err   = beat && S_AXIS_TLAST;
        info_load = beat && !S_AXIS_TLAST;
      end
      PAYLOAD: begin
        S_AXIS_TREADY = skid_ready;
        skid_in_valid = S_AXIS_TVALID;
        // Close the output packet on the counted last word or any early TLAST.
        skid_in_last  = last_word || S_AXIS_TLAST;
        len_err       = beat && (S_AXIS_TLAST ? !end_here : end_here);
      end
      TRAILER: begin
        len_err = beat && !S_AXIS_TLAST;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      run_reg            <= 1'b0;
      t_reg              <= 1'b0;
      rem_reg            <= '0;
      cnt_reg            <= '0;
      prev_cnt_reg       <= '0;
      seq_seen_reg       <= 1'b0;
      sid_shadow_reg     <= '0;
      sec_shadow_reg     <= '0;
      fsec_hi_reg        <= '0;
      pkt_stream_id_reg  <= '0;
      pkt_ts_sec_reg     <= '0;
      pkt_ts_fsec_reg    <= '0;
      pkt_info_valid_reg <= 1'b0;
      err_len_reg        <= '0;
      err_seq_reg        <= '0;
      err_type_reg       <= '0;
    end else begin
      run_reg            <= 1'b1;
      pkt_info_valid_reg <= info_load;

      if (state_reg == IDLE && beat && !hdr_bad) begin
        t_reg   <= S_AXIS_TDATA[HDR_T_BIT];
        rem_reg <= payload_words(S_AXIS_TDATA[HDR_SIZE_MSB:HDR_SIZE_LSB], S_AXIS_TDATA[HDR_T_BIT]);
        cnt_reg <= S_AXIS_TDATA[HDR_CNT_MSB:HDR_CNT_LSB];
      end
      if (state_reg == PAYLOAD && beat) rem_reg <= rem_reg - 16'd1;

      // Header words land in shadows so the published fields stay stable
      // until the next complete header.
      if (state_reg == SID    && beat) sid_shadow_reg <= S_AXIS_TDATA;
      if (state_reg == TS_SEC && beat) sec_shadow_reg <= S_AXIS_TDATA;
      if (state_reg == TSF_HI && beat) fsec_hi_reg    <= S_AXIS_TDATA;

      if (info_load) begin
        pkt_stream_id_reg <= sid_shadow_reg;
        pkt_ts_sec_reg    <= sec_shadow_reg;
        pkt_ts_fsec_reg   <= {fsec_hi_reg, S_AXIS_TDATA};
      end

      if (seq_commit) begin
        prev_cnt_reg <= cnt_reg;
        seq_seen_reg <= 1'b1;
        if (seq_bad && err_seq_reg != '1) err_seq_reg <= err_seq_reg + CNT_ONE;
      end
      if (len_err && err_len_reg != '1)   err_len_reg  <= err_len_reg + CNT_ONE;
      if (type_err && err_type_reg != '1) err_type_reg <= err_type_reg + CNT_ONE;
    end
  end

  // ------------------------------------------------------------- output stage
  vita49_skid u_skid (
    .clk       (AXIS_ACLK),
    .rst       (AXIS_ARESET),
    .in_data   (S_AXIS_TDATA),
    .in_last   (skid_in_last),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_ready),
    .out_data  (M_AXIS_TDATA),
    .out_last  (M_AXIS_TLAST),
    .out_valid (M_AXIS_TVALID),
    .out_ready (M_AXIS_TREADY)
  );

  assign pkt_stream_id  = pkt_stream_id_reg;
  assign pkt_ts_sec     = pkt_ts_sec_reg;
  assign pkt_ts_fsec    = pkt_ts_fsec_reg;
  assign pkt_info_valid = pkt_info_valid_reg;
  assign err_len_cnt    = err_len_reg;
  assign err_seq_cnt    = err_seq_reg;
  assign err_type_cnt   = err_type_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_vita49_unpack.sv
`timescale 1ns/1ps
module tb_vita49_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        enable = 1'b1;
  logic        filt_on = 1'b0;
  logic [31:0] filt_val = '0;
  logic [31:0] pkt_stream_id;
  logic [31:0] pkt_ts_sec;
  logic [63:0] pkt_ts_fsec;
  logic        pkt_info_valid;
  logic [15:0] err_len_cnt;
  logic [15:0] err_seq_cnt;
  logic [15:0] err_type_cnt;
  logic        busy;

  vita49_unpack #(.CNT_W(16), .CHECK_SEQ(1)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESET    (rst),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TREADY  (m_tready),
    .enable         (enable),
`ifdef VITA49_UNPACK_SID_FILTER_EN
    .sid_filter_en  (filt_on),
    .sid_filter     (filt_val),
`endif
    .pkt_stream_id  (pkt_stream_id),
    .pkt_ts_sec     (pkt_ts_sec),
    .pkt_ts_fsec    (pkt_ts_fsec),
    .pkt_info_valid (pkt_info_valid),
    .err_len_cnt    (err_len_cnt),
    .err_seq_cnt    (err_seq_cnt),
    .err_type_cnt   (err_type_cnt),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [32:0]  exp_q[$];    // {last, data}
  logic [127:0] info_q[$];   // {sid, sec, fsec}
  int exp_len = 0, exp_seq = 0, exp_type = 0;
  bit seq_seen = 0;
  logic [3:0] seq_prev = '0;
  int bp_mode = 0;           // 0: ready high, 1: random, 2: ready low

  function automatic logic [31:0] sec_of(input logic [31:0] sid);
    return 32'h5EC0_0000 ^ sid;
  endfunction
  function automatic logic [63:0] fsec_of(input logic [31:0] sid);
    return {32'hF5EC_0000 ^ sid, ~sid};
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  // output monitor: a handshake seen at the negedge completes at the next posedge
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("out_unexpected_qsize", 64'(exp_q.size()), 1);
      else check("out_word", {31'd0, m_tlast, m_tdata}, {31'd0, exp_q.pop_front()});
    end
    if (!rst && pkt_info_valid) begin
      if (info_q.size() == 0) check("info_unexpected_qsize", 64'(info_q.size()), 1);
      else begin
        logic [127:0] e;
        e = info_q.pop_front();
        check("info_sid", pkt_stream_id, e[127:96]);
        check("info_sec", pkt_ts_sec, e[95:64]);
        check("info_fsec", pkt_ts_fsec, e[63:0]);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 500) begin
        check("s_tready_timeout", 64'(n), 0);
        break;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // early_at: payload index carrying an early TLAST (-1 none)
  // extra:    words appended past the counted end before TLAST
  task automatic send_pkt(input logic [3:0] typ, input logic t, input logic [3:0] cnt,
                          input logic [15:0] size, input logic [31:0] sid,
                          input int early_at, input int extra, input logic [31:0] base);
    logic [31:0] hdr;
    bit ok, pass;
    int npay;
    hdr  = {typ, 1'b0, t, 6'd0, cnt, size};
    ok   = (typ == 4'b0001) && (int'(size) >= 6 + int'(t));
    pass = ok && !(filt_on && sid != filt_val);
    npay = int'(size) - 5 - int'(t);
    $display("pkt type=%0h T=%0d cnt=%0d size=%0d sid=%08h early=%0d extra=%0d", typ, t, cnt, size, sid, early_at, extra);
    if (!ok) begin
      exp_type++;
      send_beat(hdr, 1'b0);
      send_beat(sid, 1'b0);
      send_beat(32'h0BAD_0001, 1'b0);
      send_beat(32'h0BAD_0002, 1'b1);
      return;
    end
    if (pass) begin
      if (seq_seen && cnt != 4'(seq_prev + 4'd1)) exp_seq++;
      seq_prev = cnt; seq_seen = 1;
      info_q.push_back({sid, sec_of(sid), fsec_of(sid)});
      for (int i = 0; i < npay; i++) begin
        if (early_at >= 0 && i > early_at) break;
        exp_q.push_back({(i == npay - 1) || (i == early_at), base + 32'(i)});
      end
      if (early_at >= 0 && !(early_at == npay - 1 && !t)) exp_len++;
      else if (extra > 0) exp_len++;
    end
    send_beat(hdr, 1'b0);
    send_beat(sid, 1'b0);
    send_beat(sec_of(sid), 1'b0);
    send_beat(fsec_of(sid) >> 32, 1'b0);
    send_beat(fsec_of(sid) & 64'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < npay; i++) begin
      send_beat(base + 32'(i), (i == early_at) || (i == npay - 1 && !t && extra == 0));
      if (i == early_at) return;
    end
    if (t) send_beat(32'h7A11_E500, extra == 0);
    for (int i = 0; i < extra; i++) send_beat(32'hE7A0_0000 + 32'(i), i == extra - 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || info_q.size() != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size() + info_q.size()), 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_len"},  err_len_cnt,  16'(exp_len));
    check({tag, "_seq"},  err_seq_cnt,  16'(exp_seq));
    check({tag, "_type"}, err_type_cnt, 16'(exp_type));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_len = 0; exp_seq = 0; exp_type = 0; seq_seen = 0;
    exp_q.delete(); info_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_info_valid", pkt_info_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sid", pkt_stream_id, 0);
    check("rst_fsec", pkt_ts_fsec, 0);
    check_counters("rst");
    rst = 1'b0;

    // basic packet, size 10, no trailer, payload A0..A4
    send_pkt(4'h1, 1'b0, 4'd0, 16'd10, 32'hCAFE_0001, -1, 0, 32'hA0);
    drain("drain_basic");
    check("basic_sid", pkt_stream_id, 32'hCAFE_0001);
    check_counters("basic");

    // trailer present, size 11
    send_pkt(4'h1, 1'b1, 4'd1, 16'd11, 32'hCAFE_0002, -1, 0, 32'hB0);
    drain("drain_trailer");
    check_counters("trailer");

    // early TLAST on 3rd payload word, then a clean packet
    send_pkt(4'h1, 1'b0, 4'd2, 16'd10, 32'hCAFE_0003, 2, 0, 32'hC0);
    send_pkt(4'h1, 1'b0, 4'd3, 16'd10, 32'hCAFE_0004, -1, 0, 32'hD0);
    drain("drain_early");
    check_counters("early");

    // bad type, bad sizes, minimum legal size
    send_pkt(4'h4, 1'b0, 4'd4, 16'd10, 32'hCAFE_0005, -1, 0, 32'hE0);
    send_pkt(4'h1, 1'b0, 4'd4, 16'd5,  32'hCAFE_0006, -1, 0, 32'hE8);
    send_pkt(4'h1, 1'b1, 4'd4, 16'd6,  32'hCAFE_0007, -1, 0, 32'hEC);
    send_pkt(4'h1, 1'b0, 4'd4, 16'd6,  32'hCAFE_0008, -1, 0, 32'hF0);
    drain("drain_bad");
    check_counters("bad");

    // missing TLAST on counted last word: tail discarded
    send_pkt(4'h1, 1'b0, 4'd5, 16'd8, 32'hCAFE_0009, -1, 2, 32'h10);
    send_pkt(4'h1, 1'b0, 4'd6, 16'd7, 32'hCAFE_000A, -1, 0, 32'h20);
    drain("drain_missing");
    check_counters("missing");

    // enable low holds off a new packet
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("en_low_tready", s_tready, 0);
    check("en_low_busy", busy, 0);
    enable = 1'b1;

    // reset mid-packet with a payload beat stuck at the output
    bp_mode = 2;
    @(posedge clk); #1;
    info_q.push_back({32'hDEAD_0001, sec_of(32'hDEAD_0001), fsec_of(32'hDEAD_0001)});
    send_beat({4'h1, 1'b0, 1'b0, 6'd0, 4'd7, 16'd10}, 1'b0);
    send_beat(32'hDEAD_0001, 1'b0);
    send_beat(sec_of(32'hDEAD_0001), 1'b0);
    send_beat(fsec_of(32'hDEAD_0001) >> 32, 1'b0);
    send_beat(fsec_of(32'hDEAD_0001) & 64'hFFFF_FFFF, 1'b0);
    send_beat(32'h5555_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_m_tvalid_stall", m_tvalid, 1);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #2;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_tready", s_tready, 0);
    bp_mode = 0;
    do_reset();
    check_counters("mid_rst");
    send_pkt(4'h1, 1'b0, 4'd9, 16'd9, 32'hCAFE_000B, -1, 0, 32'h30);
    drain("drain_after_rst");
    check_counters("after_rst");

    // sequence 14,15,0,2 under random back-pressure
    do_reset();
    bp_mode = 1;
    send_pkt(4'h1, 1'b0, 4'd14, 16'd12, 32'hCAFE_0010, -1, 0, 32'h100);
    send_pkt(4'h1, 1'b1, 4'd15, 16'd13, 32'hCAFE_0011, -1, 0, 32'h200);
    send_pkt(4'h1, 1'b0, 4'd0,  16'd9,  32'hCAFE_0012, -1, 0, 32'h300);
    send_pkt(4'h1, 1'b0, 4'd2,  16'd20, 32'hCAFE_0013, -1, 0, 32'h400);
    drain("drain_seq");
    check("seq_err_cnt", err_seq_cnt, 1);
    check_counters("seq");
    bp_mode = 0;

`ifdef VITA49_UNPACK_SID_FILTER_EN
    filt_on = 1'b1;
    filt_val = 32'h0000_1234;
    send_pkt(4'h1, 1'b0, 4'd3, 16'd10, 32'h0000_1234, -1, 0, 32'h500);
    send_pkt(4'h1, 1'b0, 4'd9, 16'd10, 32'h0000_9999, -1, 0, 32'h600);
    drain("drain_filter");
    check("filter_sid", pkt_stream_id, 32'h0000_1234);
    check_counters("filter");
    filt_on = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
